// File: rtl/reg_bank_ctrl.sv
// reg_bank_ctrl: turns write/read/move commands into reg_bank port sequences.
// Optional WRITE_VERIFY_EN adds a post-write readback check and sticky wr_err.
module reg_bank_ctrl #(
  parameter int DW     = 64,
  parameter int RD_LAT = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [3:0]    cmd_dst,
  input  logic [3:0]    cmd_srcA,
  input  logic [3:0]    cmd_srcB,
  input  logic [1:0]    cmd_mode,
  input  logic [DW-1:0] cmd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_dataA,
  output logic [DW-1:0] rsp_dataB,
  output logic          regwen,
  output logic [DW-1:0] inA,
  output logic [3:0]    selwreg,
  output logic [1:0]    endreg,
  output logic [3:0]    seloutA,
  output logic [3:0]    seloutB,
  output logic          cnstA,
  output logic          cnstB,
  output logic          enrregA,
  output logic          enrregB,
  input  logic [DW-1:0] outA,
  input  logic [DW-1:0] outB
`ifdef WRITE_VERIFY_EN
  ,
  output logic          wr_err
`endif
);

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_MV  = 2'b10;
  localparam logic [1:0] OP_RC  = 2'b11;
  localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_REQ,
    RD_WAIT,
    MV_WR,
    RESP
`ifdef WRITE_VERIFY_EN
    ,
    VF_REQ,
    VF_WAIT
`endif
  } state_t;

  state_t     state, state_n;
  logic [1:0] op_q, mode_q, cnt;
  logic [3:0] dst_q;
  logic       accept, wait_done;

  assign cmd_ready = (state == IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign wait_done = (cnt == 2'd0);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept)
                 state_n = (cmd_op == OP_WR) ? WR : RD_REQ;
`ifdef WRITE_VERIFY_EN
      WR:      state_n = VF_REQ;
      MV_WR:   state_n = VF_REQ;
      VF_REQ:  state_n = VF_WAIT;
      VF_WAIT: if (wait_done)
                 state_n = (op_q == OP_MV) ? RESP : IDLE;
`else
      WR:      state_n = IDLE;
      MV_WR:   state_n = RESP;
`endif
      RD_REQ:  state_n = RD_WAIT;
      RD_WAIT: if (wait_done)
                 state_n = (op_q == OP_MV) ? MV_WR : RESP;
      RESP:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

`ifdef WRITE_VERIFY_EN
  localparam int HW = DW / 2;
  logic vf_bad;

  // inA/endreg still hold the last write, so they are the reference
  always_comb begin
    vf_bad = 1'b0;
    unique case (endreg)
      2'b00:   vf_bad = (outA != inA);
      2'b10:   vf_bad = (outA[HW-1:0] != inA[HW-1:0]);
      2'b01:   vf_bad = (outA[DW-1:HW] != inA[DW-1:HW]);
      default: vf_bad = 1'b0;
    endcase
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      op_q      <= '0;
      mode_q    <= '0;
      dst_q     <= '0;
      cnt       <= '0;
      regwen    <= 1'b0;
      inA       <= '0;
      selwreg   <= '0;
      endreg    <= '0;
      seloutA   <= '0;
      seloutB   <= '0;
      cnstA     <= 1'b0;
      cnstB     <= 1'b0;
      enrregA   <= 1'b0;
      enrregB   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_dataA <= '0;
      rsp_dataB <= '0;
`ifdef WRITE_VERIFY_EN
      wr_err    <= 1'b0;
`endif
    end else begin
      regwen  <= 1'b0;
      enrregA <= 1'b0;
      enrregB <= 1'b0;
      unique case (state)
        IDLE: if (accept) begin
          op_q   <= cmd_op;
          mode_q <= cmd_mode;
          dst_q  <= cmd_dst;
          if (cmd_op == OP_WR) begin
            regwen  <= 1'b1;
            selwreg <= cmd_dst;
            endreg  <= cmd_mode;
            inA     <= cmd_data;
          end else begin
            seloutA <= cmd_srcA;
            enrregA <= 1'b1;
            cnstA   <= (cmd_op == OP_RC);
            if (cmd_op != OP_MV) begin
              seloutB <= cmd_srcB;
              enrregB <= 1'b1;
              cnstB   <= (cmd_op == OP_RC);
            end
          end
        end
`ifdef WRITE_VERIFY_EN
        WR, MV_WR: begin
          seloutA <= dst_q;
          enrregA <= 1'b1;
          cnstA   <= 1'b0;
        end
        RD_REQ, VF_REQ: cnt <= LAT_M1;
        VF_WAIT: begin
          if (!wait_done) cnt <= cnt - 2'd1;
          else begin
            if (vf_bad) wr_err <= 1'b1;
            if (op_q == OP_MV) rsp_valid <= 1'b1;
          end
        end
`else
        WR: ;
        MV_WR: rsp_valid <= 1'b1;
        RD_REQ: cnt <= LAT_M1;
`endif
        RD_WAIT: begin
          if (!wait_done) cnt <= cnt - 2'd1;
          else begin
            rsp_dataA <= outA;
            if (op_q == OP_MV) begin
              regwen  <= 1'b1;
              selwreg <= dst_q;
              endreg  <= mode_q;
              inA     <= outA;
            end else begin
              rsp_dataB <= outB;
              rsp_valid <= 1'b1;
            end
          end
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// tb_reg_bank_ctrl: scoreboard bench with a behavioural reg_bank and command model.
// Define WRITE_VERIFY_EN to also exercise the readback-verify path.
module tb_reg_bank_ctrl;
  localparam int DW = 64;
  localparam int HW = DW / 2;
  localparam int RD_LAT = 1;

  logic          clock, reset;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op, cmd_mode;
  logic [3:0]    cmd_dst, cmd_srcA, cmd_srcB;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_dataA, rsp_dataB;
  logic          regwen;
  logic [DW-1:0] inA;
  logic [3:0]    selwreg, seloutA, seloutB;
  logic [1:0]    endreg;
  logic          cnstA, cnstB, enrregA, enrregB;
  logic [DW-1:0] outA, outB;
`ifdef WRITE_VERIFY_EN
  logic          wr_err;
`endif

  reg_bank_ctrl #(.DW(DW), .RD_LAT(RD_LAT)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst),
    .cmd_srcA(cmd_srcA), .cmd_srcB(cmd_srcB),
    .cmd_mode(cmd_mode), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_dataA(rsp_dataA), .rsp_dataB(rsp_dataB),
    .regwen(regwen), .inA(inA), .selwreg(selwreg),
    .endreg(endreg), .seloutA(seloutA), .seloutB(seloutB),
    .cnstA(cnstA), .cnstB(cnstB),
    .enrregA(enrregA), .enrregB(enrregB),
    .outA(outA), .outB(outB)
`ifdef WRITE_VERIFY_EN
    , .wr_err(wr_err)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] gold[16];
  logic [DW-1:0] bank[16];
  logic [DW-1:0] last_b;
  int            checks = 0;
  int            failures = 0;
  logic          hold = 1'b0;
  logic          corrupt = 1'b0;

  function automatic logic [DW-1:0] konst(input logic [3:0] s);
    logic [DW-1:0] k;
    k = 64'hC0DE_0000_0000_0000;
    k[3:0] = s;
    return k;
  endfunction

  // register update rule for a write with a given endreg mode
  function automatic logic [DW-1:0] apply(input logic [DW-1:0] old,
                                          input logic [DW-1:0] d,
                                          input logic [1:0] m);
    case (m)
      2'b00:   return d;
      2'b10:   return {old[DW-1:HW], d[HW-1:0]};
      2'b01:   return {d[DW-1:HW], old[HW-1:0]};
      default: return {old[HW-1:0], old[DW-1:HW]};
    endcase
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // behavioural reg_bank seen by the DUT
  always @(posedge clock) begin
    if (regwen) bank[selwreg] <= apply(bank[selwreg], inA, endreg);
    if (enrregA)
      outA <= (cnstA ? konst(seloutA) : bank[seloutA])
              ^ {{(DW-1){1'b0}}, corrupt};
    if (enrregB)
      outB <= cnstB ? konst(seloutB) : bank[seloutB];
  end

  always begin
    @(posedge clock);
    #1 rsp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // response monitor
  logic          prev_stall = 1'b0;
  logic          prev_wen = 1'b0;
  logic [DW-1:0] prev_a, prev_b;
  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
      prev_wen   = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", DW'(rsp_valid), DW'(1));
        chk("hold_dataA", rsp_dataA, prev_a);
        chk("hold_dataB", rsp_dataB, prev_b);
      end
      if (rsp_valid) chk("ready_in_resp", DW'(cmd_ready), DW'(0));
      if (regwen && prev_wen) chk("regwen_pulse", DW'(2), DW'(1));
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp actual=%h required=none", rsp_dataA);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_dataA", rsp_dataA, e.a);
          chk("rsp_dataB", rsp_dataB, e.b);
        end
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_a     = rsp_dataA;
      prev_b     = rsp_dataB;
      prev_wen   = regwen;
    end
  end

  task automatic model_accept(input logic [1:0] op, input logic [3:0] dst,
                              input logic [3:0] a, input logic [3:0] b,
                              input logic [1:0] m, input logic [DW-1:0] d,
                              input logic ovr, input logic [DW-1:0] ea,
                              input logic [DW-1:0] eb);
    exp_t e;
    e = '0;
    case (op)
      2'b00: gold[dst] = apply(gold[dst], d, m);
      2'b01: begin e.a = gold[a]; e.b = gold[b]; end
      2'b11: begin e.a = konst(a); e.b = konst(b); end
      default: begin
        e.a = gold[a];
        e.b = last_b;
        gold[dst] = apply(gold[dst], e.a, m);
      end
    endcase
    if (op != 2'b00) begin
      if (ovr) begin e.a = ea; e.b = eb; end
      last_b = e.b;
      exp_q.push_back(e);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] dst,
                       input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] m, input logic [DW-1:0] d,
                       input logic ovr, input logic [DW-1:0] ea,
                       input logic [DW-1:0] eb);
    int n = 0;
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op = op; cmd_dst = dst; cmd_srcA = a;
    cmd_srcB = b; cmd_mode = m; cmd_data = d;
    while (!cmd_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", DW'(cmd_ready), DW'(1));
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clock);
    model_accept(op, dst, a, b, m, d, ovr, ea, eb);
    #1 cmd_valid = 1'b0;
    if (op == 2'b00) begin
      @(negedge clock);
      chk("wr_strobe", DW'(regwen), DW'(1));
      chk("wr_sel", DW'({selwreg, endreg}), DW'({dst, m}));
      chk("wr_data", inA, d);
`ifndef WRITE_VERIFY_EN
      @(negedge clock);
      chk("wr_done", DW'({regwen, cmd_ready}), DW'(2'b01));
`endif
    end
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clock);
    while (!(exp_q.size() == 0 && cmd_ready) && n < 1000) begin
      @(negedge clock);
      n++;
    end
    chk("drain", DW'(exp_q.size()), DW'(0));
  endtask

  task automatic check_reset_state();
    chk("rst_ctl", DW'({regwen, selwreg, endreg, seloutA, seloutB,
                        cnstA, cnstB, enrregA, enrregB, rsp_valid}),
        DW'(0));
    chk("rst_inA", inA, '0);
    chk("rst_dataA", rsp_dataA, '0);
    chk("rst_dataB", rsp_dataB, '0);
    chk("rst_ready", DW'(cmd_ready), DW'(0));
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clock);
    #1 reset = 1'b1;
    repeat (cycles) begin
      @(negedge clock);
      chk("rst_rsp_valid", DW'(rsp_valid), DW'(0));
    end
    check_reset_state();
    @(posedge clock);
    #1 reset = 1'b0;
    exp_q.delete();
    last_b = '0;
    @(negedge clock);
    chk("ready_after_rst", DW'(cmd_ready), DW'(1));
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = '0; cmd_dst = '0; cmd_srcA = '0;
    cmd_srcB = '0; cmd_mode = '0; cmd_data = '0;
    rsp_ready = 1'b0;
    outA = '0; outB = '0;
    last_b = '0;
    for (int i = 0; i < 16; i++) begin
      gold[i] = '0;
      bank[i] = '0;
    end
    do_reset(3);

    issue(2'b00, 4'd10, 4'd0, 4'd0, 2'b00, 64'd24, 1'b0, '0, '0);
    issue(2'b01, 4'd0, 4'd10, 4'd11, 2'b00, '0, 1'b1, 64'd24, 64'd0);

    issue(2'b00, 4'd3, 4'd0, 4'd0, 2'b00, 64'h1111_2222_3333_4444,
          1'b0, '0, '0);
    issue(2'b00, 4'd3, 4'd0, 4'd0, 2'b10, '1, 1'b0, '0, '0);
    issue(2'b01, 4'd0, 4'd3, 4'd3, 2'b00, '0, 1'b1,
          64'h1111_2222_FFFF_FFFF, 64'h1111_2222_FFFF_FFFF);

    issue(2'b10, 4'd5, 4'd3, 4'd0, 2'b11, '0, 1'b1,
          64'h1111_2222_FFFF_FFFF, 64'h1111_2222_FFFF_FFFF);
    issue(2'b01, 4'd0, 4'd5, 4'd3, 2'b00, '0, 1'b0, '0, '0);
    issue(2'b10, 4'd3, 4'd3, 4'd0, 2'b11, '0, 1'b1,
          64'h1111_2222_FFFF_FFFF, gold[3]);
    issue(2'b01, 4'd0, 4'd3, 4'd3, 2'b00, '0, 1'b1,
          64'hFFFF_FFFF_1111_2222, 64'hFFFF_FFFF_1111_2222);
    issue(2'b11, 4'd0, 4'd2, 4'd9, 2'b00, '0, 1'b1,
          64'hC0DE_0000_0000_0002, 64'hC0DE_0000_0000_0009);
    drain();

    // abort a read in flight with a long reset
    issue(2'b01, 4'd0, 4'd3, 4'd5, 2'b00, '0, 1'b0, '0, '0);
    do_reset(20);

    // stall the response and poke ignored commands
    hold = 1'b1;
    issue(2'b01, 4'd0, 4'd7, 4'd3, 2'b00, '0, 1'b0, '0, '0);
    begin
      int n = 0;
      while (!rsp_valid && n < 50) begin
        @(negedge clock);
        n++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      cmd_valid = i[0];
      cmd_op = 2'b00; cmd_dst = 4'd7; cmd_mode = 2'b00;
      cmd_data = {$urandom, $urandom};
    end
    @(negedge clock);
    chk("stall_valid", DW'(rsp_valid), DW'(1));
    cmd_valid = 1'b0;
    hold = 1'b0;
    issue(2'b01, 4'd0, 4'd7, 4'd7, 2'b00, '0, 1'b0, '0, '0);
    drain();

    for (int i = 0; i < 200; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      issue(op, 4'($urandom), 4'($urandom), 4'($urandom),
            2'($urandom), {$urandom, $urandom}, 1'b0, '0, '0);
    end
    for (int i = 0; i < 16; i++)
      issue(2'b01, 4'd0, 4'(i), 4'(15 - i), 2'b00, '0, 1'b0, '0, '0);
    drain();

`ifdef WRITE_VERIFY_EN
    chk("wr_err_clean", DW'(wr_err), DW'(0));
    corrupt = 1'b1;
    issue(2'b00, 4'd9, 4'd0, 4'd0, 2'b00, {$urandom, $urandom},
          1'b0, '0, '0);
    drain();
    corrupt = 1'b0;
    chk("wr_err_set", DW'(wr_err), DW'(1));
    issue(2'b01, 4'd0, 4'd9, 4'd1, 2'b00, '0, 1'b0, '0, '0);
    drain();
    chk("wr_err_sticky", DW'(wr_err), DW'(1));
    do_reset(3);
    chk("wr_err_cleared", DW'(wr_err), DW'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
